fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, fetches words over a req/valid
// handshake, exposes opcode/immediate to the controller and applies its
// PC decisions. A HALT opcode parks the unit until reset.
module fetch_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 12,
  parameter logic [3:0] HALT_OP = 4'b1111
) (
  input  logic                   CLK,
  input  logic                   CLB,
  output logic                   MemReq,
  output logic [PC_WIDTH-1:0]    MemAddr,
  input  logic                   MemValid,
  input  logic [INSTR_WIDTH-1:0] MemData,
  input  logic                   LoadIR,
  input  logic                   IncPC,
  input  logic                   LoadPC,
  input  logic                   SelPC,
  input  logic [PC_WIDTH-1:0]    RegData,
  output logic [3:0]             Opcode,
  output logic [7:0]             Imm,
  output logic                   InstrValid,
  output logic [PC_WIDTH-1:0]    PC,
  output logic                   Halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t                   state_reg;
  state_t                   state_next;
  logic [PC_WIDTH-1:0]      pc_reg;
  logic [INSTR_WIDTH-1:0]   ir_reg;
  logic                     mem_req_reg;

  // Opcode field of the held instruction, used for the HALT decision.
  logic [3:0]               ir_opcode;
  // Branch target taken from the low bits of the immediate field.
  logic [PC_WIDTH-1:0]      imm_target;
  // Controller commits a non-HALT instruction this cycle.
  logic                     commit;

  assign ir_opcode  = ir_reg[INSTR_WIDTH-1 -: 4];
  assign imm_target = ir_reg[PC_WIDTH-1:0];
  assign commit     = (state_reg == S_EXEC) && LoadIR && (ir_opcode != HALT_OP);

  // State register; MemReq is registered by looking at the next state so it
  // is high exactly for the cycles spent in FETCH.
  always_ff @(posedge CLK) begin
    if (CLB) begin
      state_reg   <= S_IDLE;
      mem_req_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mem_req_reg <= (state_next == S_FETCH);
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: if (MemValid) state_next = S_EXEC;
      S_EXEC: begin
        if (LoadIR) begin
          if (ir_opcode == HALT_OP) state_next = S_HALT;
          else                      state_next = S_FETCH;
        end
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from registers only; MemData never reaches Opcode/Imm
  // without passing through IR.
  always_comb begin
    InstrValid = (state_reg == S_EXEC);
    Halted     = (state_reg == S_HALT);
    Opcode     = 4'b0000;
    Imm        = 8'h00;
    if (state_reg == S_EXEC) begin
      Opcode = ir_opcode;
      Imm    = ir_reg[7:0];
    end
  end

  // IR captures only on a valid response while fetching; responses in any
  // other state (including the dead IDLE cycle) are dropped.
  always_ff @(posedge CLK) begin
    if (CLB) begin
      ir_reg <= '0;
    end else if ((state_reg == S_FETCH) && MemValid) begin
      ir_reg <= MemData;
    end
  end

  // PC update on commit: branch load beats increment, increment wraps.
  always_ff @(posedge CLK) begin
    if (CLB) begin
      pc_reg <= '0;
    end else if (commit) begin
      if (LoadPC)     pc_reg <= SelPC ? RegData : imm_target;
      else if (IncPC) pc_reg <= pc_reg + PC_WIDTH'(1);
    end
  end

  assign MemReq  = mem_req_reg;
  assign MemAddr = pc_reg;
  assign PC      = pc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        CLB;
  logic        MemReq;
  logic [7:0]  MemAddr;
  logic        MemValid;
  logic [11:0] MemData;
  logic        LoadIR;
  logic        IncPC;
  logic        LoadPC;
  logic        SelPC;
  logic [7:0]  RegData;
  logic [3:0]  Opcode;
  logic [7:0]  Imm;
  logic        InstrValid;
  logic [7:0]  PC;
  logic        Halted;

  int checks   = 0;
  int failures = 0;

  fetch_unit dut (
    .CLK(CLK), .CLB(CLB), .MemReq(MemReq), .MemAddr(MemAddr),
    .MemValid(MemValid), .MemData(MemData), .LoadIR(LoadIR),
    .IncPC(IncPC), .LoadPC(LoadPC), .SelPC(SelPC), .RegData(RegData),
    .Opcode(Opcode), .Imm(Imm), .InstrValid(InstrValid), .PC(PC),
    .Halted(Halted)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic txn(input string what);
    $display("txn %-8s pc=%02h addr=%02h req=%0d op=%0h imm=%02h iv=%0d halt=%0d",
             what, PC, MemAddr, MemReq, Opcode, Imm, InstrValid, Halted);
  endtask

  initial begin
    CLB = 1'b1; MemValid = 1'b1; MemData = 12'h105;
    LoadIR = 1'b1; IncPC = 1'b1; LoadPC = 1'b0; SelPC = 1'b0; RegData = 8'h00;

    // Reset with a response pending: IDLE, everything cleared.
    step();
    txn("reset");
    check("rst_memreq", MemReq, 0);
    check("rst_pc", PC, 0);
    check("rst_iv", InstrValid, 0);
    check("rst_halted", Halted, 0);
    check("rst_opcode", Opcode, 0);

    // Back-to-back fetch with MemValid held high.
    CLB = 1'b0;
    step();  // IDLE -> FETCH, MemValid ignored in IDLE
    txn("fetch");
    check("f0_memreq", MemReq, 1);
    check("f0_addr", MemAddr, 8'h00);
    check("f0_iv", InstrValid, 0);
    step();
    txn("exec");
    check("e0_opcode", Opcode, 4'h1);
    check("e0_imm", Imm, 8'h05);
    check("e0_memreq", MemReq, 0);
    check("e0_iv", InstrValid, 1);
    MemData = 12'h207;
    step();
    txn("fetch");
    check("f1_addr", MemAddr, 8'h01);
    check("f1_memreq", MemReq, 1);
    step();
    txn("exec");
    check("e1_opcode", Opcode, 4'h2);
    check("e1_imm", Imm, 8'h07);
    step();
    txn("fetch");
    check("f2_addr", MemAddr, 8'h02);

    // Three-cycle memory wait: request and address stay put, no capture.
    MemValid = 1'b0; MemData = 12'h3AB;
    for (int i = 0; i < 3; i++) begin
      step();
      txn("wait");
      check("w_memreq", MemReq, 1);
      check("w_addr", MemAddr, 8'h02);
      check("w_iv", InstrValid, 0);
      check("w_opcode", Opcode, 0);
    end
    MemValid = 1'b1; MemData = 12'h73C;
    step();
    txn("exec");
    check("w_cap_opcode", Opcode, 4'h7);
    check("w_cap_imm", Imm, 8'h3C);
    check("w_cap_pc", PC, 8'h02);

    // Branch to immediate: LoadPC beats IncPC.
    MemValid = 1'b0;
    LoadPC = 1'b1; SelPC = 1'b0; IncPC = 1'b1; RegData = 8'h91;
    step();
    txn("fetch");
    check("br_imm_addr", MemAddr, 8'h3C);
    MemValid = 1'b1; MemData = 12'h73C;
    step();
    // Branch to register value.
    MemValid = 1'b0; SelPC = 1'b1;
    step();
    txn("fetch");
    check("br_reg_addr", MemAddr, 8'h91);

    // Load 0xFF, then increment wraps to 0.
    MemValid = 1'b1; MemData = 12'h100;
    step();
    MemValid = 1'b0; RegData = 8'hFF;
    step();
    check("ld_ff_pc", PC, 8'hFF);
    MemValid = 1'b1; MemData = 12'h200;
    step();
    MemValid = 1'b0; LoadPC = 1'b0; IncPC = 1'b1;
    step();
    txn("fetch");
    check("wrap_pc", PC, 8'h00);

    // Four-cycle stall in EXEC; a stray response must not touch IR.
    MemValid = 1'b1; MemData = 12'h2C5;
    step();
    LoadIR = 1'b0; LoadPC = 1'b1; IncPC = 1'b1; MemData = 12'h999;
    for (int i = 0; i < 4; i++) begin
      step();
      txn("stall");
      check("st_pc", PC, 8'h00);
      check("st_iv", InstrValid, 1);
      check("st_opcode", Opcode, 4'h2);
      check("st_imm", Imm, 8'hC5);
      check("st_memreq", MemReq, 0);
    end
    LoadIR = 1'b1; LoadPC = 1'b0; MemValid = 1'b0;
    step();
    txn("fetch");
    check("st_done_pc", PC, 8'h01);

    // HALT: parks until reset despite responses and control activity.
    MemValid = 1'b1; MemData = 12'hF00;
    step();
    check("h_opcode", Opcode, 4'hF);
    MemValid = 1'b0;
    step();
    txn("halt");
    check("h_halted", Halted, 1);
    check("h_pc", PC, 8'h01);
    for (int i = 0; i < 20; i++) begin
      MemValid = i[0]; LoadPC = i[1];
      step();
      check("h_memreq", MemReq, 0);
      check("h_hold", {Halted, InstrValid, Opcode, PC}, {1'b1, 1'b0, 4'h0, 8'h01});
    end
    MemValid = 1'b0; LoadPC = 1'b0;
    CLB = 1'b1;
    step();
    txn("reset");
    check("hr_pc", PC, 0);
    check("hr_halted", Halted, 0);
    check("hr_memreq", MemReq, 0);
    CLB = 1'b0;
    step();
    txn("fetch");
    check("hr_fetch_req", MemReq, 1);
    check("hr_fetch_addr", MemAddr, 8'h00);

    // Reset mid-fetch with responses in the reset and IDLE cycles.
    CLB = 1'b1; MemValid = 1'b1; MemData = 12'h5AA;
    step();
    check("mr_iv", InstrValid, 0);
    check("mr_memreq", MemReq, 0);
    CLB = 1'b0;
    step();
    txn("fetch");
    check("mr_fetch_req", MemReq, 1);
    check("mr_opcode", Opcode, 0);
    MemData = 12'h3C7;
    step();
    txn("exec");
    check("mr_cap_opcode", Opcode, 4'h3);
    check("mr_cap_imm", Imm, 8'hC7);
    check("mr_cap_pc", PC, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
